ra_stack: RTL and testbench
===========================

# ra_stack

Return-address stack for the MIPS pipeline's ID stage. It pushes the link address on every JAL/JALR and pops a predicted target on every `jr $31`, so fetch can redirect before the register operand is read. When the real `$31` value resolves in EX, the block compares it with the prediction and flags a mispredict. It pairs with the JR target-select logic: that logic consumes the register target, and this block produces the early guess and checks it.

## Interface
Parameters:
- DEPTH, 8, number of stack entries; must be a power of two, at least 2
- PTR_W, 3, pointer width, equal to log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- instr  input  32  instruction word currently in ID
- instr_valid  input  1  `instr` is a real instruction (not a bubble)
- flush  input  1  squash the ID instruction this cycle
- link_addr  input  32  PC+4 of the instruction in ID
- resolve_valid  input  1  a `jr $31` is in EX with its operand available
- resolve_target  input  32  actual `$31` value for that JR
- pred_valid  output  1  combinational; a prediction is offered this cycle
- pred_target  output  32  combinational; predicted JR target
- mispredict  output  1  registered; one-cycle pulse on a wrong or missing prediction
- depth  output  PTR_W+1  registered; number of valid entries, 0..DEPTH

## Operation
- Decode is qualified by `instr_valid & ~flush`. The qualified instruction is classified as follows:
  - push: `instr[31:26]==6'b000011` (JAL), or `instr[31:26]==0` and `instr[5:0]==6'b001001` (JALR)
  - pop: `instr[31:26]==0`, `instr[5:0]==6'b001000` and `instr[25:21]==5'd31`
  - A JR whose rs is not 31 is neither push nor pop.
- Storage is a circular array `mem[DEPTH]`, a top pointer `tp` (index of the next free slot) and a counter `cnt`. `depth` equals `cnt`.
- Push: write `mem[tp] <= link_addr`, then `tp <= tp+1` (mod DEPTH), then `cnt <= min(cnt+1, DEPTH)`.
  - On overflow the oldest entry is silently overwritten; `cnt` stays at DEPTH.
- Pop with `cnt>0`:
  - `pred_valid=1`, `pred_target=mem[tp-1]`
  - then `tp <= tp-1`, `cnt <= cnt-1`
- Pop with `cnt==0`: `pred_valid=0`, `pred_target=0`. Pointers do not change.
- Pending check: every qualified pop loads `pend_valid <= pred_valid` and `pend_target <= pred_target`.
- Resolve: when `resolve_valid` is high, `mispredict <= ~pend_valid | (pend_target != resolve_target)`, and `pend_valid <= 0`. In all other cycles `mispredict <= 0`.
- A pop and a resolve in the same cycle are legal. The resolve compares against the old pending value; the pop then loads the new one.
- `flush` does not roll back the stack; only the current ID instruction is masked.
- Comparisons use the full 32 bits. The pointer wraps modulo DEPTH.

## Timing
- Reset, sampled on a clk edge, clears:
  - `tp=0`, `cnt=0` (so `depth=0`)
  - `pend_valid=0`, `pend_target=0`
  - `mispredict=0`
  - `mem` contents are don't-care.
- Reset has priority over push, pop and resolve in the same cycle.
- `pred_valid`/`pred_target` have zero latency (combinational in ID). Stack state updates on the next edge.
- A push in cycle N is visible to a pop in cycle N+1. No same-cycle bypass is needed, because one instruction cannot both push and pop.
- `mispredict` is asserted in the cycle after `resolve_valid` and lasts exactly one cycle.
- With `pred_valid=0`, `pred_target` is 0.

## Test plan
- **Reset state:** reset for 2 cycles, then idle → `depth=0`, `mispredict=0`, `pred_valid=0`.
- **Correct call/return:** JAL with `link_addr=0x0000_0104`, next cycle `jr $31` → `pred_valid=1`, `pred_target=0x104`, `depth` goes 1→0. A resolve with `resolve_target=0x104` then gives `mispredict=0`.
- **Wrong target:** same sequence, but resolve with `0x0000_0200` → `mispredict=1` for exactly one cycle.
- **Overflow:** 9 JALs with link values 0x10..0x90 step 0x10, then 9 pops →
  - `depth` saturates at 8
  - the first 8 pops predict 0x90, 0x80, …, 0x20
  - the 9th pop gives `pred_valid=0`
  - resolving that 9th pop gives `mispredict=1`.
- **Filtering:** `jr $5`, a JAL with `flush=1`, and a JALR with `instr_valid=0` → `depth` is unchanged and `pred_valid=0` throughout.
- **Overlap and mid-operation reset:**
  - A pop and a resolve in the same cycle → the resolve uses the old pending target and the new pop's pending check is still performed later.
  - Asserting reset with `depth=3` → `depth=0` on the next cycle and no `mispredict`.

Source files
------------

// File: rtl/ra_stack.sv
`default_nettype none
// ============================================================================
// Module   : ra_stack
// Purpose  : Return-address stack; early JR $31 target guess plus EX-stage check
// Revision : 1.0 - initial release
// ============================================================================
module ra_stack #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   input  logic             flush,
   input  logic [31:0]      link_addr,
   input  logic             resolve_valid,
   input  logic [31:0]      resolve_target,
   output logic             pred_valid,
   output logic [31:0]      pred_target,
   output logic             mispredict,
   output logic [PTR_W:0]   depth
);

   localparam logic [PTR_W:0]   c_full    = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   c_cnt_one = 1;
   localparam logic [PTR_W-1:0] c_ptr_one = 1;

   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_tp;
   logic [PTR_W:0]   r_cnt;
   logic             r_pend_valid;
   logic [31:0]      r_pend_target;
   logic             r_mispredict;

   logic             w_qual;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_top_idx;

   // Masked compares keep every instruction bit in the decode expression.
   assign w_qual    = instr_valid & ~flush;
   assign w_push    = w_qual & (((instr & 32'hFC00_0000) == 32'h0C00_0000) |
                                ((instr & 32'hFC00_003F) == 32'h0000_0009));
   assign w_pop     = w_qual & ((instr & 32'hFFE0_003F) == 32'h03E0_0008);
   assign w_top_idx = r_tp - c_ptr_one;

   always_comb begin
      pred_valid  = 1'b0;
      pred_target = 32'h0;
      if (w_pop && (r_cnt != '0)) begin
         pred_valid  = 1'b1;
         pred_target = r_mem[w_top_idx];
      end
   end

   // Storage is not reset; entries beyond cnt are never read.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_tp] <= link_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tp          <= '0;
         r_cnt         <= '0;
         r_pend_valid  <= 1'b0;
         r_pend_target <= 32'h0;
         r_mispredict  <= 1'b0;
      end else begin
         r_mispredict <= 1'b0;
         if (w_push) begin
            r_tp <= r_tp + c_ptr_one;
            if (r_cnt != c_full) begin
               r_cnt <= r_cnt + c_cnt_one;
            end
         end else if (pred_valid) begin
            r_tp  <= w_top_idx;
            r_cnt <= r_cnt - c_cnt_one;
         end
         // Resolve sees the old pending entry; a same-cycle pop then replaces it.
         if (resolve_valid) begin
            r_mispredict <= ~r_pend_valid | (r_pend_target != resolve_target);
            r_pend_valid <= 1'b0;
         end
         if (w_pop) begin
            r_pend_valid  <= pred_valid;
            r_pend_target <= pred_target;
         end
      end
   end

   assign mispredict = r_mispredict;
   assign depth      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ra_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_ra_stack
// Purpose  : Scoreboard bench for ra_stack with a queue-based reference stack
// Revision : 1.0 - initial release
// ============================================================================
module tb_ra_stack;

   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int K_NONE = 0;
   localparam int K_PUSH = 1;
   localparam int K_POP  = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      instr;
   logic             instr_valid;
   logic             flush;
   logic [31:0]      link_addr;
   logic             resolve_valid;
   logic [31:0]      resolve_target;
   logic             pred_valid;
   logic [31:0]      pred_target;
   logic             mispredict;
   logic [PTR_W:0]   depth;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] m_stk [$];
   logic        m_pv;
   logic [31:0] m_pt;
   logic        exp_q [$];

   ra_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .flush          (flush),
      .link_addr      (link_addr),
      .resolve_valid  (resolve_valid),
      .resolve_target (resolve_target),
      .pred_valid     (pred_valid),
      .pred_target    (pred_target),
      .mispredict     (mispredict),
      .depth          (depth)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_jal();
      return {6'b000011, 26'h012_3456};
   endfunction

   function automatic logic [31:0] enc_jalr();
      return {6'b000000, 5'd4, 5'd0, 5'd31, 5'd0, 6'b001001};
   endfunction

   function automatic logic [31:0] enc_jr(input logic [4:0] rs);
      return {6'b000000, rs, 15'h0, 6'b001000};
   endfunction

   task automatic check_pending();
      if (exp_q.size() > 0) check("mispredict", {31'h0, mispredict}, {31'h0, exp_q.pop_front()});
   endtask

   task automatic step(input logic [31:0] ins, input logic v, input logic f,
                       input logic [31:0] link, input int kind,
                       input logic rv, input logic [31:0] rt);
      logic        e_pv;
      logic [31:0] e_pt;
      reset          = 1'b0;
      instr          = ins;
      instr_valid    = v;
      flush          = f;
      link_addr      = link;
      resolve_valid  = rv;
      resolve_target = rt;
      e_pv = 1'b0;
      e_pt = 32'h0;
      if (kind == K_POP && m_stk.size() > 0) begin
         e_pv = 1'b1;
         e_pt = m_stk[$];
      end
      @(negedge clk);
      if (exp_q.size() > 0) check_pending();
      else check("mispredict_idle", {31'h0, mispredict}, 32'h0);
      check("depth", {28'h0, depth}, m_stk.size());
      check("pred_valid", {31'h0, pred_valid}, {31'h0, e_pv});
      check("pred_target", pred_target, e_pt);
      if (rv) begin
         exp_q.push_back(!m_pv || (m_pt !== rt));
         m_pv = 1'b0;
      end
      if (kind == K_POP) begin
         m_pv = e_pv;
         m_pt = e_pt;
         if (e_pv) void'(m_stk.pop_back());
      end
      if (kind == K_PUSH) begin
         m_stk.push_back(link);
         if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rv, input logic [31:0] rt);
      step(32'h0, 1'b0, 1'b0, 32'h0, K_NONE, rv, rt);
   endtask

   // Reset cycles may carry a resolve to show reset wins; no result is expected from it.
   task automatic do_reset(input int n, input logic rv, input logic [31:0] rt);
      for (int i = 0; i < n; i++) begin
         reset          = 1'b1;
         instr          = enc_jal();
         instr_valid    = 1'b1;
         flush          = 1'b0;
         link_addr      = 32'hDEAD_0000;
         resolve_valid  = rv;
         resolve_target = rt;
         @(negedge clk);
         check_pending();
         m_stk.delete();
         exp_q.delete();
         m_pv = 1'b0;
         m_pt = 32'h0;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      m_pv = 1'b0;
      m_pt = 32'h0;
      do_reset(2, 1'b0, 32'h0);
      idle(1'b0, 32'h0);

      // Correct call/return
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_0104, K_PUSH, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b0, 32'h0);
      idle(1'b1, 32'h0000_0104);
      idle(1'b0, 32'h0);

      // Wrong target: one-cycle pulse
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_0104, K_PUSH, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b0, 32'h0);
      idle(1'b1, 32'h0000_0200);
      idle(1'b0, 32'h0);
      idle(1'b0, 32'h0);

      // Overflow: nine pushes, nine pops, resolve the empty pop
      for (int i = 1; i <= 9; i++)
         step(enc_jal(), 1'b1, 1'b0, 32'(i * 16), K_PUSH, 1'b0, 32'h0);
      for (int i = 0; i < 9; i++)
         step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b0, 32'h0);
      idle(1'b1, 32'h0000_0010);
      idle(1'b0, 32'h0);

      // Filtering: none of these touch the stack
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_0300, K_PUSH, 1'b0, 32'h0);
      step(enc_jr(5'd5), 1'b1, 1'b0, 32'h0, K_NONE, 1'b0, 32'h0);
      step(enc_jal(), 1'b1, 1'b1, 32'h0000_0400, K_NONE, 1'b0, 32'h0);
      step(enc_jalr(), 1'b0, 1'b0, 32'h0000_0500, K_NONE, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b1, 32'h0, K_NONE, 1'b0, 32'h0);
      step(enc_jalr(), 1'b1, 1'b0, 32'h0000_0600, K_PUSH, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b1, 32'h0000_0600);
      idle(1'b1, 32'h0000_0300);

      // Overlapping pop and resolve
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_00A0, K_PUSH, 1'b0, 32'h0);
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_00B0, K_PUSH, 1'b0, 32'h0);
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_00C0, K_PUSH, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b1, 32'h0000_00C0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b1, 32'h0000_0123);
      idle(1'b1, 32'h0000_00A0);
      idle(1'b0, 32'h0);

      // Mid-operation reset at depth 3 with a wrong resolve in the reset cycle
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_1000, K_PUSH, 1'b0, 32'h0);
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_2000, K_PUSH, 1'b0, 32'h0);
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_3000, K_PUSH, 1'b0, 32'h0);
      step(enc_jal(), 1'b1, 1'b0, 32'h0000_4000, K_PUSH, 1'b0, 32'h0);
      step(enc_jr(5'd31), 1'b1, 1'b0, 32'h0, K_POP, 1'b0, 32'h0);
      do_reset(1, 1'b1, 32'hFFFF_FFFF);
      idle(1'b0, 32'h0);
      idle(1'b1, 32'h0000_3000);
      idle(1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
